// File: rtl/mul16_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mul16_share_arbiter_if
//   Bundles the signals around a shared 16x16 multiplier arbiter: the request
//   side, the external multiplier operands and product, and the response side.
//
//   Signals:
//     req_valid [NREQ]      requester i has an operation pending
//     req_ready [NREQ]      requester i's operation is accepted this cycle
//     req_a/req_b [16*NREQ] operands, requester i at [16*i+15:16*i]
//     mul_a/mul_b [16]      operands presented to the shared multiplier
//     mul_prod [32]         product returned by the shared multiplier
//     rsp_valid/rsp_ready   response handshake
//     rsp_prod [32]         registered product
//     rsp_id [IDW]          index of the requester that owns rsp_prod
//
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding environment (requesters, multiplier, consumer)
// -----------------------------------------------------------------------------
interface mul16_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic [31:0]        mul_prod;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_prod;
  logic [IDW-1:0]     rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_prod, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_prod, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id
  );
endinterface

// File: rtl/mul16_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul16_share_arbiter
//   Shares one external combinational 16x16 unsigned multiplier between NREQ
//   requesters. A round-robin arbiter accepts at most one operation per clock,
//   steers its operands to the multiplier and registers the 32-bit product,
//   tagged with the requester index, into a single-entry response slot.
//
//   Ports:
//     clk            system clock, rising edge
//     rst            synchronous active-high reset
//     bus            mul16_share_arbiter_if.slave (requests, multiplier, response)
//     stat_clr       (MUL_ARB_STATS_EN only) clears the busy counter
//     stat_busy_cnt  (MUL_ARB_STATS_EN only) saturating count of grant cycles
//
//   Optional feature macro: MUL_ARB_STATS_EN
//
//   Parameters:
//     NREQ  number of requesters (2..8)
//     IDW   width of rsp_id, 2**IDW >= NREQ
// -----------------------------------------------------------------------------
module mul16_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef MUL_ARB_STATS_EN
  input  logic                        stat_clr,
  output logic [31:0]                 stat_busy_cnt,
`endif
  mul16_share_arbiter_if.slave        bus
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t          slot;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [31:0]    prod_q;
  logic [IDW-1:0] id_q;

  logic           hi_found;
  logic [IDW-1:0] hi_idx;
  logic           lo_found;
  logic [IDW-1:0] lo_idx;
  logic           found;
  logic [IDW-1:0] cand;
  logic           can_accept;
  logic           grant;

  // ---------------------------------------------------------------------------
  // Round-robin candidate search.
  // The wrapped search from ptr is split into two priority scans: the lowest
  // valid index at or above ptr wins; failing that, the lowest valid index
  // overall (the wrapped part). Scanning downward lets the last hit win.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
  end

  // With no candidate, cand falls back to ptr so the operand mux still selects
  // a real (non-X) requester lane.
  assign found      = hi_found | lo_found;
  assign cand       = hi_found ? hi_idx : (lo_found ? lo_idx : ptr);
  assign can_accept = (slot == SLOT_EMPTY) | bus.rsp_ready;
  assign grant      = found & can_accept & ~rst;
  assign ptr_next   = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;

  // One-hot grant and operand steering.
  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand == IDW'(i)) begin
        bus.req_ready[i] = grant;
        bus.mul_a        = bus.req_a[16*i +: 16];
        bus.mul_b        = bus.req_b[16*i +: 16];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response slot. A grant always loads the slot (overwriting a result that is
  // draining the same cycle); otherwise a handshake on the response empties it
  // while product and id keep their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      slot   <= SLOT_EMPTY;
      prod_q <= '0;
      id_q   <= '0;
      ptr    <= '0;
    end else if (grant) begin
      slot   <= SLOT_FULL;
      prod_q <= bus.mul_prod;
      id_q   <= cand;
      ptr    <= ptr_next;
    end else if ((slot == SLOT_FULL) && bus.rsp_ready) begin
      slot   <= SLOT_EMPTY;
    end
  end

  assign bus.rsp_valid = (slot == SLOT_FULL);
  assign bus.rsp_prod  = prod_q;
  assign bus.rsp_id    = id_q;

`ifdef MUL_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Busy counter: counts grant cycles, saturates at all-ones; clear wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_busy_cnt <= '0;
    end else if (grant && (stat_busy_cnt != '1)) begin
      stat_busy_cnt <= stat_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mul16_share_arbiter.md
Name: mul16_share_arbiter

Overview:
- Shares one combinational 16x16 multiplier (multiplier_32_bit) between NREQ requesters, such as NTT butterfly lanes or basemul units in the Kyber-512 polynomial multiplication path.
- Round-robin arbitration with valid/ready handshakes, one accepted operation per clock.
- Registered 32-bit product output, tagged with the requester index.
- Drives the external multiplier's operands and captures its product.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operation.
- req_ready  output  NREQ  bit i: requester i's operation is accepted this cycle (combinational).
- req_a  input  16*NREQ  operand A, requester i at [16*i+15:16*i].
- req_b  input  16*NREQ  operand B, same packing.
- mul_a  output  16  operand A to the shared multiplier.
- mul_b  output  16  operand B to the shared multiplier.
- mul_prod  input  32  product from the shared multiplier (combinational from mul_a/mul_b).
- rsp_valid  output  1  rsp_prod/rsp_id valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_prod  output  32  registered product.
- rsp_id  output  IDW  index of the requester that owns rsp_prod.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_prod=0, rsp_id=0, round-robin pointer ptr=0.
- req_ready is all-zero while rst=1.
- Slot state: output register is EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready.
- Arbitration:
  - Search req_valid starting at index ptr, ascending, wrapping at NREQ-1 to 0.
  - The first set bit g is the candidate.
  - Grant: req_ready = one-hot(g) when can_accept and any req_valid; otherwise 0.
  - At most one req_ready bit is set in any cycle.
- Operand mux: mul_a = req_a[g], mul_b = req_b[g].
  - With no candidate, mul_a and mul_b hold the value for index ptr; the value is don't-care but must not be X after reset.
- On a grant (handshake i):
  - rsp_prod <= mul_prod, rsp_id <= g, rsp_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- Drain: rsp_valid && rsp_ready with no new grant sets rsp_valid <= 0.
  - rsp_prod and rsp_id keep their last values.
- Simultaneous drain and grant: the new result overwrites the slot and rsp_valid stays 1, giving throughput of 1 op/cycle.
- Backpressure: while rsp_valid && !rsp_ready:
  - rsp_prod and rsp_id hold stable.
  - req_ready = 0.
  - ptr holds.
- Latency: exactly one cycle from handshake to rsp_valid.
- Arithmetic: unsigned 16x16 -> 32; no truncation, no reduction.
- Fairness: a continuously asserted requester is granted within NREQ grants.
- Requester rule: once asserted, req_valid stays high with stable operands until its req_ready. The arbiter does not rely on this rule for correctness.
- Reset mid-operation: any pending response is discarded and rsp_valid=0 the next cycle. No partial state remains.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- When defined, adds output stat_busy_cnt (32 bit) and input stat_clr (1 bit).
- stat_busy_cnt increments by 1 on every cycle with a grant and saturates at 0xFFFFFFFF.
- stat_busy_cnt clears on rst or stat_clr; stat_clr wins over a simultaneous increment.
- When not defined, neither port exists and there is no counter logic. Core behaviour is identical either way.

Test Plan:
- Single request:
  - Stimulus: rst released, requester 2 sends a=0x1234, b=0x0010, rsp_ready=1.
  - Response: req_ready=0100 in the same cycle; next cycle rsp_valid=1, rsp_prod=0x00012340, rsp_id=2.
- Max operands:
  - Stimulus: requester 0 sends a=0xFFFF, b=0xFFFF.
  - Response: rsp_prod=0xFFFE0001, rsp_id=0.
- Round-robin:
  - Stimulus: all 4 requesters hold valid continuously, rsp_ready=1.
  - Response: rsp_id sequence 0,1,2,3,0,1 on consecutive cycles with rsp_valid constantly 1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after the first result (a=3, b=5).
  - Response: rsp_prod=15 stays stable, req_ready=0000 throughout, ptr unchanged; when rsp_ready rises, the next grant happens the same cycle.
- Reset with a result pending:
  - Stimulus: rst=1 for one cycle while rsp_valid=1 and rsp_ready=0.
  - Response: next cycle rsp_valid=0, rsp_prod=0, rsp_id=0; the first grant after reset goes to the lowest valid index at or above 0.
- Stats (MUL_ARB_STATS_EN):
  - Stimulus: 5 grants, then stat_clr asserted together with a grant.
  - Response: stat_busy_cnt reads 5, then 0.
